// File: rtl/td_reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined reduction cone.
// Op encoding, identity element, group reduce and tree-shape functions.
package td_reduce_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   // Pad value for short groups: 1 for AND-style ops, 0 otherwise.
   function automatic logic ident(logic [1:0] op);
      return (op == OP_AND) || (op == OP_NAND);
   endfunction

   // Reduce one group of up to four bits. NAND reduces as AND here;
   // the inversion is applied only at the final output.
   function automatic logic grp_red(logic [1:0] op, logic [3:0] b);
      logic r;
      case (op)
         OP_OR:   r = |b;
         OP_XOR:  r = ^b;
         default: r = &b;
      endcase
      return r;
   endfunction

   // Width of the tree after k levels.
   function automatic int lvl_w(int m, int fanin, int k);
      int w;
      w = m;
      for (int i = 0; i < k; i++) w = (w + fanin - 1) / fanin;
      return w;
   endfunction

   // Bit offset of level k's vector inside the flattened tree bus.
   function automatic int lvl_off(int m, int fanin, int k);
      int o;
      o = 0;
      for (int i = 0; i < k; i++) o += lvl_w(m, fanin, i);
      return o;
   endfunction

   // Number of tree levels, never less than one.
   function automatic int levels(int n_in, int fanin, int nand_front);
      int w;
      int l;
      w = n_in - nand_front;
      l = 0;
      while (w > 1) begin
         w = (w + fanin - 1) / fanin;
         l++;
      end
      return (l < 1) ? 1 : l;
   endfunction

endpackage

// File: rtl/td_reduce_level.sv
// One reduction level: FANIN-ary group reduce plus its pipeline register.
// Ports: clk_i/rst_i, adv_i (stage loads), vld/op/tap/d in and out.
module td_reduce_level
   import td_reduce_pkg::*;
#(
   parameter int WI = 5,
   parameter int FANIN = 4,
   localparam int WO = (WI + FANIN - 1) / FANIN
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          adv_i,
   input  logic          vld_i,
   input  logic [1:0]    op_i,
   input  logic          tap_i,
   input  logic [WI-1:0] d_i,
   output logic          vld_o,
   output logic [1:0]    op_o,
   output logic          tap_o,
   output logic [WO-1:0] d_o
);

   localparam int PW = WO * FANIN;

   logic [PW-1:0] pad;
   logic [3:0]    chunk;
   logic [WO-1:0] d_d;
   logic [WO-1:0] d_q;
   logic          vld_q;
   logic [1:0]    op_q;
   logic          tap_q;

   // Short trailing group is filled with the op's identity element.
   always_comb begin
      pad = {PW{ident(op_i)}};
      pad[WI-1:0] = d_i;
      chunk = '0;
      d_d = '0;
      for (int g = 0; g < WO; g++) begin
         chunk = {4{ident(op_i)}};
         chunk[FANIN-1:0] = pad[g*FANIN +: FANIN];
         d_d[g] = grp_red(op_i, chunk);
      end
   end

   // Payload only loads with a valid word, so a bubble never disturbs it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= 1'b0;
         op_q  <= '0;
         tap_q <= 1'b0;
         d_q   <= '0;
      end else if (adv_i) begin
         vld_q <= vld_i;
         if (vld_i) begin
            op_q  <= op_i;
            tap_q <= tap_i;
            d_q   <= d_d;
         end
      end
   end

   assign vld_o = vld_q;
   assign op_o  = op_q;
   assign tap_o = tap_q;
   assign d_o   = d_q;

endmodule

// File: rtl/td_reduce_pipe.sv
// Pipelined FANIN-ary logic-reduction cone with valid/ready on both sides.
// Ports: clk, rst, a/op/in_valid/in_ready, y_red/y_tap/out_valid/out_ready, out_count.
module td_reduce_pipe
   import td_reduce_pkg::*;
#(
   parameter int N_IN = 6,
   parameter int FANIN = 4,
   parameter int NAND_FRONT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] a,
   input  logic [1:0]      op,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            y_red,
   output logic            y_tap,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [15:0]     out_count
);

   localparam int M  = N_IN - NAND_FRONT;
   localparam int L  = levels(N_IN, FANIN, NAND_FRONT);
   localparam int T  = lvl_off(M, FANIN, L + 1);
   localparam int FG = (FANIN < M) ? FANIN : M;

   // Flattened tree: operands at offset 0, each level's results after.
   logic [T-1:0]     bus;
   logic [L:1]       stv;
   logic [L:0]       tap;
   logic [2*L+1:0]   opv;
   logic [L+1:1]     adv;
   logic [3:0]       g0;
   logic             acc;
   logic [15:0]      cnt_d;
   logic [15:0]      cnt_q;

   if (NAND_FRONT != 0) begin : g_nf
      assign bus[M-1:0] = {a[N_IN-1:2], ~(a[0] & a[1])};
   end else begin : g_raw
      assign bus[M-1:0] = a;
   end

   // Level-1 group 0 result enters the tap chain with its transaction.
   always_comb begin
      g0 = {4{ident(op)}};
      g0[FG-1:0] = bus[FG-1:0];
   end

   assign tap[0]   = grp_red(op, g0);
   assign opv[1:0] = op;

   // Ready ripples back from the output; empty stages collapse bubbles.
   always_comb begin
      adv = '0;
      adv[L+1] = out_ready;
      for (int k = L; k >= 1; k--) adv[k] = ~stv[k] | adv[k+1];
   end

   assign in_ready = adv[1] & ~rst;
   assign acc      = in_valid & in_ready;

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int WIK = lvl_w(M, FANIN, k - 1);
      localparam int WOK = lvl_w(M, FANIN, k);
      localparam int OI  = lvl_off(M, FANIN, k - 1);
      localparam int OO  = lvl_off(M, FANIN, k);
      logic vin;
      if (k == 1) begin : g_first
         assign vin = acc;
      end else begin : g_next
         assign vin = stv[k-1];
      end
      td_reduce_level #(
         .WI    (WIK),
         .FANIN (FANIN)
      ) u_lvl (
         .clk_i (clk),
         .rst_i (rst),
         .adv_i (adv[k]),
         .vld_i (vin),
         .op_i  (opv[2*k-1:2*k-2]),
         .tap_i (tap[k-1]),
         .d_i   (bus[OI +: WIK]),
         .vld_o (stv[k]),
         .op_o  (opv[2*k+1:2*k]),
         .tap_o (tap[k]),
         .d_o   (bus[OO +: WOK])
      );
   end

   assign out_valid = stv[L] & ~rst;
   assign y_tap     = tap[L];
   assign y_red     = (opv[2*L+1:2*L] == OP_NAND) ? ~bus[T-1] : bus[T-1];

   assign cnt_d = cnt_q + 16'(out_valid & out_ready);

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign out_count = cnt_q;

endmodule

// File: tb/tb_td_reduce_pipe.sv
// Bench for td_reduce_pipe: default build plus N_IN=9/FANIN=2/no NAND build.
// Table vectors, handshake corner sequences and a random model sweep.
module tb_td_reduce_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [5:0]  a1;
   logic [1:0]  op1;
   logic        iv1, ir1, yr1, yt1, ov1, or1;
   logic [15:0] c1;

   logic [8:0]  a2;
   logic [1:0]  op2;
   logic        iv2, ir2, yr2, yt2, ov2, or2;
   logic [15:0] c2;

   td_reduce_pipe dut1 (
      .clk(clk), .rst(rst), .a(a1), .op(op1), .in_valid(iv1),
      .in_ready(ir1), .y_red(yr1), .y_tap(yt1), .out_valid(ov1),
      .out_ready(or1), .out_count(c1)
   );

   td_reduce_pipe #(.N_IN(9), .FANIN(2), .NAND_FRONT(0)) dut2 (
      .clk(clk), .rst(rst), .a(a2), .op(op2), .in_valid(iv2),
      .in_ready(ir2), .y_red(yr2), .y_tap(yt2), .out_valid(ov2),
      .out_ready(or2), .out_count(c2)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0] a;
      logic [1:0] op;
      logic       yr;
      logic       yt;
   } vec_t;

   typedef struct {
      logic [1:0] v;
      int         c;
   } ent_t;

   vec_t       tbl [8];
   logic [1:0] ex [$];
   logic [1:0] got1 [$];
   ent_t       q1 [$];
   ent_t       q2 [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Flat reduction over the operand list; the tree result must match it.
   function automatic logic [1:0] model(logic [31:0] a, int n, int f,
                                       int nf, logic [1:0] op);
      bit q [$];
      bit r, t;
      if (nf != 0) begin
         q.push_back(!(a[0] && a[1]));
         for (int i = 2; i < n; i++) q.push_back(a[i]);
      end else begin
         for (int i = 0; i < n; i++) q.push_back(a[i]);
      end
      r = (op == 2'b00) || (op == 2'b11);
      t = r;
      for (int i = 0; i < q.size(); i++) begin
         case (op)
            2'b01:   r = r | q[i];
            2'b10:   r = r ^ q[i];
            default: r = r & q[i];
         endcase
         if (i < f) t = r;
      end
      if (op == 2'b11) r = !r;
      return {r, t};
   endfunction

   always @(posedge clk)
      if (!rst && ov1 && or1) got1.push_back({yr1, yt1});

   task automatic send_chk(input vec_t v, input string nm);
      int lat;
      @(negedge clk);
      a1 = v.a; op1 = v.op; iv1 = 1'b1; or1 = 1'b1;
      #1;
      chk({nm, "_rdy"}, ir1, 1);
      @(negedge clk);
      iv1 = 1'b0;
      lat = 1;
      #1;
      while (!ov1 && lat < 8) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk({nm, "_lat"}, lat, 2);
      chk({nm, "_yred"}, yr1, v.yr);
      chk({nm, "_ytap"}, yt1, v.yt);
   endtask

   task automatic rnd1();
      a1 = 6'($urandom);
      op1 = 2'($urandom);
   endtask

   task automatic cmp_drain(input string nm, input int n, input int cnt);
      or1 = 1'b1;
      iv1 = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk({nm, "_n"}, got1.size(), n);
      for (int i = 0; i < n && i < got1.size(); i++)
         chk({nm, "_data"}, got1[i], ex[i]);
      chk({nm, "_cnt"}, c1, cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int pops1, pops2;
      tbl[0] = '{6'b111100, 2'b00, 1'b1, 1'b1};
      tbl[1] = '{6'b111111, 2'b00, 1'b0, 1'b0};
      tbl[2] = '{6'b000000, 2'b01, 1'b1, 1'b1};
      tbl[3] = '{6'b000111, 2'b10, 1'b1, 1'b1};
      tbl[4] = '{6'b111100, 2'b11, 1'b0, 1'b1};
      tbl[5] = '{6'b000011, 2'b01, 1'b0, 1'b0};
      tbl[6] = '{6'b101010, 2'b10, 1'b1, 1'b0};
      tbl[7] = '{6'b011110, 2'b11, 1'b1, 1'b1};

      rst = 1'b1;
      a1 = '0; op1 = '0; iv1 = 1'b0; or1 = 1'b1;
      a2 = '0; op2 = '0; iv2 = 1'b0; or2 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", ir1, 0);
      chk("rst_out_valid", ov1, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ov", ov1, 0);
      chk("post_rst_cnt", c1, 0);
      chk("post_rst_yred", yr1, 0);
      chk("post_rst_ytap", yt1, 0);
      chk("post_rst_rdy", ir1, 1);
      chk("post_rst_rdy2", ir2, 1);

      for (int i = 0; i < 8; i++) send_chk(tbl[i], $sformatf("tbl%0d", i));

      // Backpressure: only L words fit, held output stays put.
      @(negedge clk);
      #1;
      chk("cnt_tbl", c1, 8);
      ex.delete(); got1.delete();
      or1 = 1'b0; iv1 = 1'b1; acc = 0;
      for (int i = 0; i < 4; i++) begin
         rnd1();
         #1;
         if (ir1) begin
            ex.push_back(model(32'(a1), 6, 4, 1, op1));
            acc++;
         end
         @(negedge clk);
      end
      iv1 = 1'b0;
      #1;
      chk("bp_accepted", acc, 2);
      chk("bp_full_rdy", ir1, 0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", ov1, 1);
         chk("bp_hold_data", {yr1, yt1}, ex[0]);
         @(negedge clk);
         #1;
      end
      cmp_drain("bp", 2, 10);
      chk("bp_rdy_after", ir1, 1);

      // Full pipe, input and output handshake on the same edge.
      ex.delete(); got1.delete();
      @(negedge clk);
      or1 = 1'b0; iv1 = 1'b1;
      repeat (2) begin
         rnd1();
         #1;
         chk("fs_fill_rdy", ir1, 1);
         ex.push_back(model(32'(a1), 6, 4, 1, op1));
         @(negedge clk);
      end
      rnd1();
      or1 = 1'b1;
      #1;
      chk("fs_in_rdy", ir1, 1);
      chk("fs_out_vld", ov1, 1);
      ex.push_back(model(32'(a1), 6, 4, 1, op1));
      @(negedge clk);
      or1 = 1'b0;
      rnd1();
      #1;
      chk("fs_still_full", ir1, 0);
      chk("fs_vld", ov1, 1);
      iv1 = 1'b0;
      cmp_drain("fs", 3, 13);

      // Reset with two words in flight.
      ex.delete(); got1.delete();
      @(negedge clk);
      or1 = 1'b0; iv1 = 1'b1;
      repeat (2) begin
         rnd1();
         @(negedge clk);
      end
      iv1 = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_rdy", ir1, 0);
      chk("mid_rst_vld", ov1, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_post_vld", ov1, 0);
      chk("mid_post_cnt", c1, 0);
      chk("mid_post_rdy", ir1, 1);
      or1 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("mid_no_stale", got1.size(), 0);
      chk("mid_no_stale_vld", ov1, 0);
      send_chk(tbl[0], "rst_next");

      // Random sweep of both builds against the flat model.
      pops1 = 0; pops2 = 0;
      for (int c = 0; c < 612; c++) begin
         @(negedge clk);
         iv1 = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
         iv2 = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
         rnd1();
         a2 = 9'($urandom);
         op2 = 2'($urandom);
         or1 = (c < 300 || c >= 600) ? 1'b1 : 1'($urandom_range(0, 1));
         or2 = (c < 300 || c >= 600) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         if (ov1 && or1) begin
            if (q1.size() == 0) begin
               chk("r1_extra", 1, 0);
            end else begin
               chk("r1_data", {yr1, yt1}, q1[0].v);
               if (q1[0].c < 290) chk("r1_lat", c - q1[0].c, 2);
               void'(q1.pop_front());
            end
            pops1++;
         end
         if (iv1 && ir1) q1.push_back('{model(32'(a1), 6, 4, 1, op1), c});
         if (ov2 && or2) begin
            if (q2.size() == 0) begin
               chk("r2_extra", 1, 0);
            end else begin
               chk("r2_data", {yr2, yt2}, q2[0].v);
               if (q2[0].c < 290) chk("r2_lat", c - q2[0].c, 4);
               void'(q2.pop_front());
            end
            pops2++;
         end
         if (iv2 && ir2) q2.push_back('{model(32'(a2), 9, 2, 0, op2), c});
      end
      @(negedge clk);
      #1;
      chk("r1_left", q1.size(), 0);
      chk("r2_left", q2.size(), 0);
      chk("r1_cnt", c1, 16'(1 + pops1));
      chk("r2_cnt", c2, 16'(pops2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
